// File: rtl/eqgen_pkg.sv
// eqgen_pkg: shared types and constants for the equation generator.
//   state_t   - generator FSM states
//   DATA_W    - width of all data outputs
//   QBITS     - width of the quotients q1/q2
//   LFSR_TAPS - feedback taps (bits 7,5,4,3) of the 8-bit Fibonacci LFSR
//   ZERO_SEED - substitute for the illegal all-zero LFSR state
package eqgen_pkg;
    localparam int DATA_W = 8;
    localparam int QBITS = 3;
    localparam logic [DATA_W-1:0] LFSR_TAPS = 8'hB8;
    localparam logic [DATA_W-1:0] ZERO_SEED = 8'h01;
    typedef enum logic [2:0] {IDLE, PICK_Z, PICK_Q1, PICK_Q2, CALC, OFFER} state_t;
endpackage

// File: rtl/lfsr8.sv
// lfsr8: free-running 8-bit Fibonacci LFSR (shift left) with reseed.
//   Clock, Reset     - clock, synchronous active-high reset (loads SEED)
//   SeedLoad, SeedIn - reseed this cycle; overrides the advance, 0 maps to ZERO_SEED
//   pick_bits        - low 2*QBITS bits of the current (pre-edge) LFSR state
module lfsr8
    import eqgen_pkg::*;
#(
    parameter logic [DATA_W-1:0] SEED = 8'hA5
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 SeedLoad,
    input  logic [DATA_W-1:0]    SeedIn,
    output logic [2*QBITS-1:0]   pick_bits
);
    logic [DATA_W-1:0] value;

    always_ff @(posedge Clock) begin
        if (Reset)
            value <= (SEED == '0) ? ZERO_SEED : SEED;
        else if (SeedLoad)
            value <= (SeedIn == '0) ? ZERO_SEED : SeedIn;
        else
            value <= {value[DATA_W-2:0], ^(value & LFSR_TAPS)};
    end

    assign pick_bits = value[2*QBITS-1:0];
endmodule

// File: rtl/equation_generator.sv
// equation_generator: picks a random divisor Z and quotients q1/q2, offers
// X=q1*Z, Y=q2*Z, Z and TargetOut=q1*q1+q2 on a valid/ready handshake.
//   Clock, Reset     - clock, synchronous active-high reset
//   SeedLoad, SeedIn - reseed the LFSR (0 maps to 8'h01)
//   Start            - request a new equation, honoured in IDLE only
//   Ready, Valid     - consumer handshake; outputs stable while Valid
//   Busy             - generator not idle
//   XOut, YOut, ZOut, TargetOut - the offered equation
module equation_generator
    import eqgen_pkg::*;
#(
    parameter logic [DATA_W-1:0] SEED = 8'hA5
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              SeedLoad,
    input  logic [DATA_W-1:0] SeedIn,
    input  logic              Start,
    input  logic              Ready,
    output logic              Valid,
    output logic              Busy,
    output logic [DATA_W-1:0] XOut,
    output logic [DATA_W-1:0] YOut,
    output logic [DATA_W-1:0] ZOut,
    output logic [DATA_W-1:0] TargetOut
);
    state_t state;
    logic [2*QBITS-1:0] lfsr;
    logic [3:0] z;
    logic [QBITS-1:0] q1;
    logic [QBITS-1:0] q2;

    lfsr8 #(.SEED(SEED)) u_lfsr (
        .Clock(Clock),
        .Reset(Reset),
        .SeedLoad(SeedLoad),
        .SeedIn(SeedIn),
        .pick_bits(lfsr)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
            z <= '0;
            q1 <= '0;
            q2 <= '0;
            XOut <= '0;
            YOut <= '0;
            ZOut <= '0;
            TargetOut <= '0;
        end else begin
            case (state)
                IDLE: if (Start) state <= PICK_Z;
                // A zero divisor is rejected; the LFSR moves on, so retry next cycle.
                PICK_Z: if (lfsr[3:0] != '0) begin
                    z <= lfsr[3:0];
                    state <= PICK_Q1;
                end
                PICK_Q1: begin
                    q1 <= lfsr[QBITS-1:0];
                    state <= PICK_Q2;
                end
                PICK_Q2: begin
                    q2 <= lfsr[2*QBITS-1:QBITS];
                    state <= CALC;
                end
                CALC: begin
                    XOut <= DATA_W'(q1) * DATA_W'(z);
                    YOut <= DATA_W'(q2) * DATA_W'(z);
                    ZOut <= DATA_W'(z);
                    TargetOut <= DATA_W'(q1) * DATA_W'(q1) + DATA_W'(q2);
                    state <= OFFER;
                end
                OFFER: if (Ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign Valid = (state == OFFER);
    assign Busy = (state != IDLE);
endmodule

// File: tb/tb_equation_generator.sv
// tb_equation_generator: directed and randomized checks of equation_generator
// against a cycle-level behavioural model plus hand-computed equations.
module tb_equation_generator;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic SeedLoad = 1'b0;
    logic [7:0] SeedIn = 8'h00;
    logic Start = 1'b0;
    logic Ready = 1'b0;
    logic Valid, Busy;
    logic [7:0] XOut, YOut, ZOut, TargetOut;

    int n_chk = 0;
    int n_fail = 0;
    bit armed = 1'b0;

    equation_generator #(.SEED(8'hA5)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .SeedLoad(SeedLoad),
        .SeedIn(SeedIn),
        .Start(Start),
        .Ready(Ready),
        .Valid(Valid),
        .Busy(Busy),
        .XOut(XOut),
        .YOut(YOut),
        .ZOut(ZOut),
        .TargetOut(TargetOut)
    );

    always #5 Clock = ~Clock;

    // Behavioural model: LFSR as integer arithmetic, progress as a phase number
    // 0 idle, 1 choosing Z, 2 choosing q1, 3 choosing q2, 4 computing, 5 offering.
    int m_lfsr, m_ph, m_z, m_q1, m_q2, m_x, m_y, m_zo, m_t;

    function automatic int lfsr_next(input int l);
        return ((l * 2) % 256) + (((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1);
    endfunction

    always @(posedge Clock) begin
        armed <= 1'b1;
        if (Reset) begin
            m_lfsr <= 'hA5;
            m_ph <= 0;
            m_z <= 0;
            m_q1 <= 0;
            m_q2 <= 0;
            m_x <= 0;
            m_y <= 0;
            m_zo <= 0;
            m_t <= 0;
        end else begin
            m_lfsr <= SeedLoad ? ((SeedIn == 0) ? 1 : int'(SeedIn)) : lfsr_next(m_lfsr);
            if (m_ph == 0 && Start) m_ph <= 1;
            if (m_ph == 1 && m_lfsr % 16 != 0) begin
                m_z <= m_lfsr % 16;
                m_ph <= 2;
            end
            if (m_ph == 2) begin
                m_q1 <= m_lfsr % 8;
                m_ph <= 3;
            end
            if (m_ph == 3) begin
                m_q2 <= (m_lfsr / 8) % 8;
                m_ph <= 4;
            end
            if (m_ph == 4) begin
                m_x <= m_q1 * m_z;
                m_y <= m_q2 * m_z;
                m_zo <= m_z;
                m_t <= m_q1 * m_q1 + m_q2;
                m_ph <= 5;
            end
            if (m_ph == 5 && Ready) m_ph <= 0;
        end
    end

    always @(negedge Clock) begin
        if (armed) begin
            n_chk++;
            if (Valid !== (m_ph == 5) || Busy !== (m_ph != 0) || XOut !== 8'(m_x) ||
                YOut !== 8'(m_y) || ZOut !== 8'(m_zo) || TargetOut !== 8'(m_t)) begin
                n_fail++;
                $display("FAIL model t=%0t got V=%b B=%b X=%0d Y=%0d Z=%0d T=%0d expected V=%b B=%b X=%0d Y=%0d Z=%0d T=%0d",
                         $time, Valid, Busy, XOut, YOut, ZOut, TargetOut,
                         m_ph == 5, m_ph != 0, m_x, m_y, m_zo, m_t);
            end
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clock);
        #2;
    endtask

    task automatic check_zero(input string nm);
        @(negedge Clock);
        chk({nm, " Valid"}, Valid, 0);
        chk({nm, " Busy"}, Busy, 0);
        chk({nm, " X"}, XOut, 0);
        chk({nm, " Y"}, YOut, 0);
        chk({nm, " Z"}, ZOut, 0);
        chk({nm, " T"}, TargetOut, 0);
    endtask

    task automatic launch(input logic [7:0] s);
        SeedLoad = 1'b1;
        SeedIn = s;
        Start = 1'b1;
        tick;
        SeedLoad = 1'b0;
        Start = 1'b0;
    endtask

    // Counts edges after the Start edge until Valid is seen; bounded.
    task automatic wait_valid(output int lat);
        lat = 0;
        @(negedge Clock);
        while (!Valid && lat < 30) begin
            tick;
            lat++;
            @(negedge Clock);
        end
        if (!Valid) chk("valid timeout", 0, 1);
    endtask

    task automatic expect_eq(input string nm, input int lat_e, input int z, input int x,
                             input int y, input int t);
        int lat;
        wait_valid(lat);
        chk({nm, " latency"}, lat, lat_e);
        chk({nm, " Z"}, ZOut, z);
        chk({nm, " X"}, XOut, x);
        chk({nm, " Y"}, YOut, y);
        chk({nm, " T"}, TargetOut, t);
    endtask

    initial begin
        int lat;
        repeat (3) tick;
        check_zero("in reset");
        tick;
        Reset = 1'b0;
        repeat (3) tick;
        check_zero("idle after reset");
        tick;

        Ready = 1'b1;
        launch(8'h1B);
        expect_eq("seed1B", 4, 11, 66, 55, 41);
        tick;
        @(negedge Clock);
        chk("valid drop", Valid, 0);
        tick;

        launch(8'h10);
        expect_eq("zretry", 5, 1, 3, 0, 9);
        tick;

        launch(8'h00);
        expect_eq("zeroseed", 4, 1, 2, 0, 4);
        tick;

        Ready = 1'b0;
        launch(8'h1B);
        expect_eq("backpressure", 4, 11, 66, 55, 41);
        for (int i = 0; i < 10; i++) begin
            tick;
            Start = (i % 2 == 0);
            @(negedge Clock);
            chk("bp Valid", Valid, 1);
            chk("bp X", XOut, 66);
        end
        tick;
        Start = 1'b0;
        Ready = 1'b1;
        tick;
        @(negedge Clock);
        chk("bp release Valid", Valid, 0);
        chk("bp release Busy", Busy, 0);
        chk("bp held X", XOut, 66);
        chk("bp held T", TargetOut, 41);
        tick;
        Start = 1'b1;
        tick;
        Start = 1'b0;
        @(negedge Clock);
        chk("restart Busy", Busy, 1);
        wait_valid(lat);
        tick;

        Ready = 1'b0;
        launch(8'h1B);
        wait_valid(lat);
        tick;
        Reset = 1'b1;
        tick;
        Reset = 1'b0;
        check_zero("reset in offer");
        tick;
        Ready = 1'b1;
        launch(8'h1B);
        expect_eq("after offer reset", 4, 11, 66, 55, 41);
        tick;

        launch(8'h1B);
        tick;
        Reset = 1'b1;
        tick;
        Reset = 1'b0;
        check_zero("reset in pick_q1");
        tick;
        launch(8'h1B);
        expect_eq("after q1 reset", 4, 11, 66, 55, 41);
        tick;

        for (int i = 0; i < 600; i++) begin
            Start = ($urandom_range(0, 3) == 0);
            Ready = ($urandom_range(0, 2) != 0);
            SeedLoad = ($urandom_range(0, 15) == 0);
            SeedIn = 8'($urandom);
            Reset = ($urandom_range(0, 99) == 0);
            tick;
        end
        Reset = 1'b0;
        Start = 1'b0;
        SeedLoad = 1'b0;
        repeat (3) tick;
        @(negedge Clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
